// File: rtl/blink_rate_decoder_pkg.sv
// Shared definitions for the LED blinker and its receive-side rate decoder:
// rate select codes, default half-period constants and decoder FSM states.
package blink_rate_decoder_pkg;

    // 2-bit rate select codes, {s1,s2} convention shared with the blinker
    localparam logic [1:0] RATE_100 = 2'b00;
    localparam logic [1:0] RATE_50  = 2'b01;
    localparam logic [1:0] RATE_10  = 2'b10;
    localparam logic [1:0] RATE_1   = 2'b11;

    // Default half-periods in clock cycles, one source for both ends of the link
    localparam int DEF_CT_100 = 125;
    localparam int DEF_CT_50  = 250;
    localparam int DEF_CT_10  = 1250;
    localparam int DEF_CT_1   = 12500;
    localparam int DEF_TOL    = 8;

    // Decoder lock state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } brd_state_t;

endpackage

// File: rtl/blink_rate_decoder_sync_edge_detect.sv
// Brings an asynchronous board input into the clock domain with a 2-flop
// synchronizer, delays it one more cycle and flags every transition
// (rising or falling) as a one-cycle pulse.
module blink_rate_decoder_sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_det
);

    logic meta_p0;
    logic sync_p1;
    logic dly_p2;

    // Synchronizer pair followed by the delay flop used for edge comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dly_p2  <= 1'b0;
        end else begin
            meta_p0 <= din;
            sync_p1 <= meta_p0;
            dly_p2  <= sync_p1;
        end
    end

    assign edge_det = sync_p1 ^ dly_p2;

endmodule

// File: rtl/blink_rate_decoder.sv
// Measures the half-period of an incoming blink square wave, classifies it
// into one of the four blinker rates and locks onto it after LOCK_N
// consecutive matching measurements. A constant input times out to IDLE.
module blink_rate_decoder
    import blink_rate_decoder_pkg::*;
#(
    parameter int CT_100 = DEF_CT_100,
    parameter int CT_50  = DEF_CT_50,
    parameter int CT_10  = DEF_CT_10,
    parameter int CT_1   = DEF_CT_1,
    parameter int TOL    = DEF_TOL,
    parameter int LOCK_N = 2,
    parameter int CNT_W  = 15
) (
    input  logic             i_clck,
    input  logic             i_rst,
    input  logic             i_blink,
    output logic [1:0]       o_rate,
    output logic             o_valid,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_period
);

    localparam int               TMO        = CT_1 + TOL + 1;
    localparam logic [CNT_W-1:0] CNT_TMO    = CNT_W'(TMO);
    localparam logic [CNT_W-1:0] CNT_TMO_M1 = CNT_W'(TMO - 1);
    // One spare count of headroom so mc never wraps while acquiring
    localparam int               MC_W       = $clog2(LOCK_N + 2);
    localparam logic [MC_W-1:0]  MC_LOCK    = MC_W'(LOCK_N);

    // Cycle counter increment that parks at the timeout value
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_TMO) return CNT_TMO;
        return v + CNT_W'(1);
    endfunction

    // True when measurement m lies within +/-TOL of nominal half-period ct
    function automatic logic near(input logic [CNT_W-1:0] m, input int ct);
        logic signed [31:0] d;
        d = $signed(32'(m)) - ct;
        return (d <= TOL) && (d >= -TOL);
    endfunction

    logic             edge_det;
    logic [CNT_W-1:0] cnt;
    logic             m_hit;
    logic [1:0]       m_code;
    brd_state_t       state;
    logic [1:0]       cand;
    logic [MC_W-1:0]  mc;
    logic [1:0]       cand_nxt;
    logic [MC_W-1:0]  mc_nxt;

    blink_rate_decoder_sync_edge_detect u_sync_edge_detect (
        .clk      (i_clck),
        .rst      (i_rst),
        .din      (i_blink),
        .edge_det (edge_det)
    );

    // Cycles since the last edge; the value on an edge cycle is the measurement
    always_ff @(posedge i_clck or posedge i_rst) begin
        if (i_rst)         cnt <= '0;
        else if (edge_det) cnt <= CNT_W'(1);
        else               cnt <= sat_inc(cnt);
    end

    // Latch every measurement for status/self-test visibility
    always_ff @(posedge i_clck or posedge i_rst) begin
        if (i_rst)         o_period <= '0;
        else if (edge_det) o_period <= cnt;
    end

    // Classify the current count against the four rate windows
    always_comb begin
        m_hit  = 1'b1;
        m_code = RATE_100;
        if (near(cnt, CT_100))     m_code = RATE_100;
        else if (near(cnt, CT_50)) m_code = RATE_50;
        else if (near(cnt, CT_10)) m_code = RATE_10;
        else if (near(cnt, CT_1))  m_code = RATE_1;
        else                       m_hit  = 1'b0;
    end

    // Candidate/match-count update applied on an edge while acquiring
    always_comb begin
        cand_nxt = cand;
        mc_nxt   = mc;
        if (m_hit) begin
            if (mc != '0 && m_code == cand) begin
                mc_nxt = mc + MC_W'(1);
            end else begin
                cand_nxt = m_code;
                mc_nxt   = MC_W'(1);
            end
        end else begin
            mc_nxt = '0;
        end
    end

    // Lock FSM with registered rate/valid/timeout outputs
    always_ff @(posedge i_clck or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cand      <= RATE_100;
            mc        <= '0;
            o_rate    <= RATE_100;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // First edge only sets the reference point
                    if (edge_det) begin
                        state <= ST_ACQUIRE;
                        mc    <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (edge_det) begin
                        cand <= cand_nxt;
                        if (mc_nxt >= MC_LOCK) begin
                            state   <= ST_LOCKED;
                            o_rate  <= cand_nxt;
                            o_valid <= 1'b1;
                            mc      <= '0;
                        end else begin
                            mc <= mc_nxt;
                        end
                    end else if (cnt == CNT_TMO_M1) begin
                        state     <= ST_IDLE;
                        mc        <= '0;
                        o_valid   <= 1'b0;
                        o_timeout <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (edge_det) begin
                        if (!(m_hit && m_code == o_rate)) begin
                            state   <= ST_ACQUIRE;
                            o_valid <= 1'b0;
                            if (m_hit) begin
                                cand <= m_code;
                                mc   <= MC_W'(1);
                            end else begin
                                mc <= '0;
                            end
                        end
                    end else if (cnt == CNT_TMO_M1) begin
                        state     <= ST_IDLE;
                        mc        <= '0;
                        o_valid   <= 1'b0;
                        o_timeout <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Bench for blink_rate_decoder: directed rate sequences, timeout, async reset
// and randomized bursts, compared every cycle against a run-length model.
module tb_blink_rate_decoder;

    localparam int TOL    = 8;
    localparam int LOCK_N = 2;
    localparam int CNT_W  = 15;
    localparam int TMO    = 12500 + TOL + 1;

    logic             clk;
    logic             i_rst;
    logic             i_blink;
    logic [1:0]       o_rate;
    logic             o_valid;
    logic             o_timeout;
    logic [CNT_W-1:0] o_period;

    int n_cmp;
    int n_bad;
    int tmo_seen;

    // Reference model state: delayed view of the input, time since last edge,
    // and the run of consecutive equal classifications since the last break.
    bit q [4];
    int elapsed;
    bit m_idle;
    int run_len;
    int run_code;
    int e_rate;
    bit e_valid;
    bit e_tmo;
    int e_period;

    blink_rate_decoder dut (
        .i_clck    (clk),
        .i_rst     (i_rst),
        .i_blink   (i_blink),
        .o_rate    (o_rate),
        .o_valid   (o_valid),
        .o_timeout (o_timeout),
        .o_period  (o_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ct_of(input int c);
        case (c)
            0:       return 125;
            1:       return 250;
            2:       return 1250;
            default: return 12500;
        endcase
    endfunction

    function automatic int classify(input int m);
        for (int i = 0; i < 4; i++) begin
            int d;
            d = m - ct_of(i);
            if (d <= TOL && d >= -TOL) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) q[i] = 1'b0;
        elapsed  = 0;
        m_idle   = 1'b1;
        run_len  = 0;
        run_code = 0;
        e_rate   = 0;
        e_valid  = 1'b0;
        e_tmo    = 1'b0;
        e_period = 0;
    endtask

    task automatic model_step(input bit b);
        bit ed;
        int m;
        int c;
        q[3] = q[2];
        q[2] = q[1];
        q[1] = q[0];
        q[0] = b;
        ed   = (q[2] != q[3]);
        m    = (elapsed > TMO) ? TMO : elapsed;
        e_tmo = 1'b0;
        if (ed) begin
            e_period = m;
            elapsed  = 1;
            if (m_idle) begin
                m_idle  = 1'b0;
                run_len = 0;
            end else begin
                c = classify(m);
                if (c < 0) run_len = 0;
                else if (run_len > 0 && c == run_code) run_len++;
                else begin
                    run_code = c;
                    run_len  = 1;
                end
                if (run_len >= LOCK_N && !e_valid) e_rate = run_code;
                e_valid = (run_len >= LOCK_N);
            end
        end else begin
            if (!m_idle && elapsed == TMO - 1) begin
                m_idle  = 1'b1;
                run_len = 0;
                e_valid = 1'b0;
                e_tmo   = 1'b1;
            end
            if (elapsed < 1000000) elapsed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (i_rst) model_reset();
        else       model_step(i_blink);
        @(negedge clk);
        chk("valid",   32'(o_valid),   32'(e_valid));
        chk("rate",    32'(o_rate),    32'(e_rate));
        chk("timeout", 32'(o_timeout), 32'(e_tmo));
        chk("period",  32'(o_period),  32'(e_period));
        if (o_timeout) tmo_seen++;
    endtask

    task automatic half(input int n);
        i_blink = ~i_blink;
        repeat (n) tick();
    endtask

    initial begin
        int rnd_cycles;
        int code;
        int len;
        int n;
        n_cmp    = 0;
        n_bad    = 0;
        tmo_seen = 0;
        i_rst    = 1'b1;
        i_blink  = 1'b0;
        model_reset();

        repeat (3) tick();
        chk("rst_valid",   32'(o_valid),   32'd0);
        chk("rst_rate",    32'(o_rate),    32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_period",  32'(o_period),  32'd0);
        i_rst = 1'b0;
        repeat (5) tick();

        // Nominal fastest rate
        repeat (5) half(125);
        chk("lock125_valid",  32'(o_valid),  32'd1);
        chk("lock125_rate",   32'(o_rate),   32'd0);
        chk("lock125_period", 32'(o_period), 32'd125);

        // Tolerance boundary, just inside then just outside
        repeat (4) half(133);
        chk("tol133_valid",  32'(o_valid),  32'd1);
        chk("tol133_period", 32'(o_period), 32'd133);
        repeat (4) half(134);
        chk("out134_valid",  32'(o_valid),  32'd0);
        chk("out134_period", 32'(o_period), 32'd134);
        repeat (3) half(188);
        chk("out188_valid",  32'(o_valid),  32'd0);
        chk("out188_period", 32'(o_period), 32'd188);

        // Lock at 250, then switch to 1250
        repeat (4) half(250);
        chk("lock250_valid", 32'(o_valid), 32'd1);
        chk("lock250_rate",  32'(o_rate),  32'd1);
        half(1250);
        half(1250);
        chk("sw1250_drop",   32'(o_valid),  32'd0);
        chk("sw1250_period", 32'(o_period), 32'd1250);
        half(1250);
        chk("lock1250_valid", 32'(o_valid), 32'd1);
        chk("lock1250_rate",  32'(o_rate),  32'd2);

        // Constant input from a locked state must time out exactly once
        repeat (4) half(250);
        chk("pre_tmo_valid", 32'(o_valid), 32'd1);
        tmo_seen = 0;
        repeat (12600) tick();
        chk("tmo_pulses",    tmo_seen,     32'd1);
        chk("tmo_valid",     32'(o_valid), 32'd0);
        chk("tmo_rate_hold", 32'(o_rate),  32'd1);
        repeat (2) half(250);
        chk("relock_early", 32'(o_valid), 32'd0);
        repeat (2) half(250);
        chk("relock_valid", 32'(o_valid), 32'd1);
        chk("relock_rate",  32'(o_rate),  32'd1);

        // Slowest rate stays below the timeout threshold
        tmo_seen = 0;
        repeat (3) half(12500);
        chk("lock12500_valid", 32'(o_valid), 32'd1);
        chk("lock12500_rate",  32'(o_rate),  32'd3);
        chk("lock12500_notmo", tmo_seen,     32'd0);

        // Randomized bursts with jitter inside and outside the windows
        rnd_cycles = 0;
        for (int b = 0; b < 14 && rnd_cycles < 15000; b++) begin
            code = int'($urandom_range(0, 7));
            len  = int'($urandom_range(1, 3));
            repeat (len) begin
                if (code < 3)       n = 125  + int'($urandom_range(0, 2 * TOL)) - TOL;
                else if (code < 6)  n = 250  + int'($urandom_range(0, 2 * TOL)) - TOL;
                else if (code == 6) n = 1250 + int'($urandom_range(0, 2 * TOL)) - TOL;
                else                n = int'($urandom_range(134, 241));
                half(n);
                rnd_cycles += n;
            end
        end

        // Asynchronous reset between clock edges while locked
        repeat (4) half(125);
        chk("prerst_valid", 32'(o_valid), 32'd1);
        repeat (40) tick();
        #2;
        i_rst   = 1'b1;
        i_blink = 1'b0;
        model_reset();
        #1;
        chk("arst_valid",   32'(o_valid),   32'd0);
        chk("arst_rate",    32'(o_rate),    32'd0);
        chk("arst_timeout", 32'(o_timeout), 32'd0);
        chk("arst_period",  32'(o_period),  32'd0);
        repeat (2) tick();
        i_rst = 1'b0;
        repeat (4) tick();
        repeat (2) half(125);
        chk("reacq_partial", 32'(o_valid), 32'd0);
        half(125);
        chk("reacq_valid", 32'(o_valid), 32'd1);
        chk("reacq_rate",  32'(o_rate),  32'd0);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
